// File: rtl/perceptron_predict_stage.sv
// Perceptron predict stage: 2-stage signed dot product over four weight
// vectors per fetch, per-slot prediction records, and a training-request FSM.
//
// Ports:
//   clk, rst (async, active-low)
//   i_valid/o_ready, i_weights, i_ghr, i_addr : weight vectors in
//   o_valid/i_ready, o_pred, o_sum            : predictions out
//   i_res_valid/o_res_ready, i_res_way/taken  : branch resolution in
//   o_upd_valid/i_upd_ready, o_upd_addr/dir   : training request out
module perceptron_predict_stage #(
    parameter int NUM_WAYS  = 4,
    parameter int HIST_LEN  = 8,
    parameter int W_WIDTH   = 8,
    parameter int SUM_WIDTH = 12,
    parameter int THETA     = 29
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_valid,
    output logic                                     o_ready,
    input  logic [NUM_WAYS*(HIST_LEN+1)*W_WIDTH-1:0] i_weights,
    input  logic [HIST_LEN-1:0]                      i_ghr,
    input  logic [NUM_WAYS*8-1:0]                    i_addr,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic [NUM_WAYS-1:0]                      o_pred,
    output logic [NUM_WAYS*SUM_WIDTH-1:0]            o_sum,
    input  logic                                     i_res_valid,
    output logic                                     o_res_ready,
    input  logic [1:0]                               i_res_way,
    input  logic                                     i_res_taken,
    output logic                                     o_upd_valid,
    input  logic                                     i_upd_ready,
    output logic [7:0]                               o_upd_addr,
    output logic                                     o_upd_dir
);

    localparam int VW   = (HIST_LEN + 1) * W_WIDTH;
    localparam int HALF = HIST_LEN / 2;
    localparam int EXT  = SUM_WIDTH - W_WIDTH;

    localparam logic signed [SUM_WIDTH-1:0] TH_P = SUM_WIDTH'(THETA);
    localparam logic signed [SUM_WIDTH-1:0] TH_N = -TH_P;

    typedef enum logic {IDLE, REQ} state_t;

    // Combinational partial sums feeding S1
    logic signed [SUM_WIDTH-1:0] lo_c [NUM_WAYS];
    logic signed [SUM_WIDTH-1:0] hi_c [NUM_WAYS];

    // S1
    logic                        s1_valid;
    logic signed [SUM_WIDTH-1:0] s1_lo [NUM_WAYS];
    logic signed [SUM_WIDTH-1:0] s1_hi [NUM_WAYS];
    logic [NUM_WAYS*8-1:0]       s1_addr;

    // S2
    logic                        s2_valid;
    logic signed [SUM_WIDTH-1:0] s2_sum [NUM_WAYS];
    logic [NUM_WAYS-1:0]         s2_pred;
    logic [NUM_WAYS*8-1:0]       s2_addr;

    // Prediction records
    logic [NUM_WAYS-1:0]         rec_valid;
    logic [7:0]                  rec_addr [NUM_WAYS];
    logic signed [SUM_WIDTH-1:0] rec_sum [NUM_WAYS];
    logic [NUM_WAYS-1:0]         rec_pred;

    state_t state;

    logic accept, s2_adv, out_fire, res_fire;
    logic r_valid, r_pred, low_conf, train;
    logic signed [SUM_WIDTH-1:0] r_sum;

    assign s2_adv   = s1_valid && (!s2_valid || i_ready);
    assign o_ready  = !s1_valid || s2_adv;
    assign accept   = i_valid && o_ready;
    assign o_valid  = s2_valid;
    assign out_fire = s2_valid && i_ready;

    always_comb begin
        logic signed [W_WIDTH-1:0]   wt;
        logic signed [SUM_WIDTH-1:0] ext, t;
        wt  = '0;
        ext = '0;
        t   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            wt = i_weights[w*VW + HIST_LEN*W_WIDTH +: W_WIDTH];
            hi_c[w] = {{EXT{wt[W_WIDTH-1]}}, wt};
            lo_c[w] = '0;
            for (int j = 0; j < HIST_LEN; j++) begin
                wt  = i_weights[w*VW + j*W_WIDTH +: W_WIDTH];
                ext = {{EXT{wt[W_WIDTH-1]}}, wt};
                // Negation happens after widening, so -128 becomes +128
                t   = i_ghr[j] ? ext : -ext;
                if (j < HALF) lo_c[w] = lo_c[w] + t;
                else          hi_c[w] = hi_c[w] + t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                s1_lo[w] <= '0;
                s1_hi[w] <= '0;
            end
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_addr  <= i_addr;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    s1_lo[w] <= lo_c[w];
                    s1_hi[w] <= hi_c[w];
                end
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_pred  <= '0;
            s2_addr  <= '0;
            for (int w = 0; w < NUM_WAYS; w++) s2_sum[w] <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= 1'b1;
                s2_addr  <= s1_addr;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    s2_sum[w]  <= s1_lo[w] + s1_hi[w];
                    s2_pred[w] <= !(s1_lo[w] + s1_hi[w] < 0);
                end
            end else if (i_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign o_pred = s2_pred;

    always_comb begin
        o_sum = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            o_sum[w*SUM_WIDTH +: SUM_WIDTH] = s2_sum[w];
    end

    // Resolution lookup and training decision
    assign o_res_ready = (state == IDLE);
    assign res_fire    = o_res_ready && i_res_valid;
    assign r_valid     = rec_valid[i_res_way];
    assign r_pred      = rec_pred[i_res_way];
    assign r_sum       = rec_sum[i_res_way];
    assign low_conf    = (r_sum <= TH_P) && (r_sum >= TH_N);
    assign train       = (r_pred != i_res_taken) || low_conf;

    // Clear precedes the overwrite so a record arriving in the same
    // cycle as its resolution survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_valid <= '0;
            rec_pred  <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                rec_addr[w] <= '0;
                rec_sum[w]  <= '0;
            end
        end else begin
            if (res_fire && r_valid) rec_valid[i_res_way] <= 1'b0;
            if (out_fire) begin
                rec_valid <= '1;
                rec_pred  <= s2_pred;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    rec_addr[w] <= s2_addr[w*8 +: 8];
                    rec_sum[w]  <= s2_sum[w];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            o_upd_valid <= 1'b0;
            o_upd_addr  <= '0;
            o_upd_dir   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (res_fire && r_valid && train) begin
                        o_upd_addr  <= rec_addr[i_res_way];
                        o_upd_dir   <= i_res_taken;
                        o_upd_valid <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (i_upd_ready) begin
                        o_upd_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
